// File: rtl/buffer_master_if.sv
// Bundle of the command, write-stream, read-stream and buffer-port signals of buffer_master.
// master = the burst initiator's view; slave = the surrounding datapath/buffer view.
interface buffer_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              buf_en;
    logic              buf_write;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic [DATA_W-1:0] buf_rdata;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready,
        output buf_en, buf_write, buf_addr, buf_wdata,
        input  buf_rdata,
        output done, err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready,
        input  buf_en, buf_write, buf_addr, buf_wdata,
        output buf_rdata,
        input  done, err
    );
endinterface

// File: rtl/buffer_master.sv
// Burst initiator for the 16x32 register buffer: write bursts from in-stream, read bursts to out-stream.
// Optional macro BUFFER_MASTER_BOUND_CHECK_EN: bursts running past the top entry are rejected with err.
module buffer_master #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    buffer_master_if.master bm
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;

    logic              cmd_ready_s;
    logic              cmd_fire_s;
    logic              bound_err_s;
    logic              wr_fire_s;
    logic              rd_issue_s;
    logic              out_hs_s;
    logic              last_beat_s;
    logic              buf_en_s;
    logic              buf_write_s;
    logic              in_ready_s;
    logic [ADDR_W-1:0] buf_addr_s;
    logic [DATA_W-1:0] buf_wdata_s;

    assign cmd_ready_s = (state_q == S_IDLE) && !out_valid_q && !reset;
    assign cmd_fire_s  = bm.cmd_valid && cmd_ready_s;
    assign wr_fire_s   = (state_q == S_WRITE) && bm.in_valid && !reset;
    assign rd_issue_s  = (state_q == S_READ) && (!out_valid_q || bm.out_ready) && !reset;
    assign out_hs_s    = out_valid_q && bm.out_ready;
    assign last_beat_s = (remain_q == ADDR_ZERO);

`ifdef BUFFER_MASTER_BOUND_CHECK_EN
    // Extra top bit keeps the carry so a run past the last entry is visible.
    assign bound_err_s = ({1'b0, bm.cmd_addr} + {1'b0, bm.cmd_len}) > {1'b0, {ADDR_W{1'b1}}};
`else
    assign bound_err_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire_s && !bound_err_s) begin
                    state_d = bm.cmd_write ? S_WRITE : S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (wr_fire_s && last_beat_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_READ: begin
                if (rd_issue_s && last_beat_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (out_hs_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: burst address/count, read output holding register, reject pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= ADDR_ZERO;
            remain_q    <= ADDR_ZERO;
            out_data_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    // Datapath next-state: load on accept, advance on each beat, refill/clear the output stage.
    always_comb begin
        addr_d      = addr_q;
        remain_d    = remain_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = cmd_fire_s && bound_err_s;
        if (cmd_fire_s && !bound_err_s) begin
            addr_d   = bm.cmd_addr;
            remain_d = bm.cmd_len;
        end else if (wr_fire_s || rd_issue_s) begin
            // Address wraps naturally at ADDR_W bits.
            addr_d   = addr_q + ADDR_ONE;
            remain_d = remain_q - ADDR_ONE;
        end else begin
            addr_d   = addr_q;
            remain_d = remain_q;
        end
        if (rd_issue_s) begin
            out_data_d  = bm.buf_rdata;
            out_valid_d = 1'b1;
        end else if (out_hs_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Buffer port and write-stream ready; combinational so the buffer captures on the handshake edge.
    always_comb begin
        buf_en_s    = 1'b0;
        buf_write_s = 1'b0;
        buf_addr_s  = addr_q;
        buf_wdata_s = {DATA_W{1'b0}};
        in_ready_s  = 1'b0;
        case (state_q)
            S_WRITE: begin
                if (!reset) begin
                    in_ready_s  = 1'b1;
                    buf_en_s    = bm.in_valid;
                    buf_write_s = 1'b1;
                    buf_wdata_s = bm.in_data;
                end else begin
                    in_ready_s  = 1'b0;
                end
            end
            S_READ: begin
                if (rd_issue_s) begin
                    buf_en_s = 1'b1;
                end else begin
                    buf_en_s = 1'b0;
                end
            end
            default: begin
                buf_en_s = 1'b0;
            end
        endcase
    end

    assign bm.cmd_ready = cmd_ready_s;
    assign bm.in_ready  = in_ready_s;
    assign bm.buf_en    = buf_en_s;
    assign bm.buf_write = buf_write_s;
    assign bm.buf_addr  = buf_addr_s;
    assign bm.buf_wdata = buf_wdata_s;
    assign bm.out_valid = out_valid_q;
    assign bm.out_data  = out_data_q;
    assign bm.done      = (state_q == S_DONE) && !reset;
    assign bm.err       = err_q && !reset;

endmodule

// File: tb/tb_buffer_master.sv
// Scoreboard bench for buffer_master: models the 16x32 buffer and predicts every buffer write
// and every read-stream beat from a high-level array model of the buffer contents.
module tb_buffer_master;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic mem_clr = 1'b1;

    always #5 clk = ~clk;

    buffer_master_if #(.DATA_W(32), .ADDR_W(4)) bm ();

    buffer_master #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bm    (bm)
    );

`ifdef BUFFER_MASTER_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    // Buffer model: synchronous write, combinational read.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
        end else if (bm.buf_en && bm.buf_write) begin
            mem[bm.buf_addr] <= bm.buf_wdata;
        end
    end
    assign bm.buf_rdata = mem[bm.buf_addr];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ref_mem [16];
    logic [35:0] exp_wr_q [$];
    logic [31:0] exp_rd_q [$];
    int          rd_issue_cnt = 0;
    int          done_cnt     = 0;
    logic        prev_stall   = 1'b0;
    logic [31:0] prev_data    = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic bit bound_err(input logic [3:0] a, input logic [3:0] l);
        return BOUND_EN && ((int'(a) + int'(l)) > 15);
    endfunction

    // Monitor: pops expectations whenever the DUT writes the buffer or hands out a read beat.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (bm.buf_en && bm.buf_write) begin
                chk("wr_without_in_valid", {63'h0, bm.in_valid}, 64'h1);
                checks++;
                if (exp_wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected actual=addr%0d/0x%0h required=no_write", bm.buf_addr, bm.buf_wdata);
                end else begin
                    logic [35:0] e;
                    e = exp_wr_q.pop_front();
                    if ({bm.buf_addr, bm.buf_wdata} !== e) begin
                        failures++;
                        $display("FAIL wr_beat actual=0x%0h required=0x%0h", {bm.buf_addr, bm.buf_wdata}, e);
                    end
                end
            end
            if (bm.buf_en && !bm.buf_write) rd_issue_cnt <= rd_issue_cnt + 1;
            if (bm.out_valid && bm.out_ready) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_unexpected actual=0x%0h required=no_beat", bm.out_data);
                end else begin
                    logic [31:0] r;
                    r = exp_rd_q.pop_front();
                    if (bm.out_data !== r) begin
                        failures++;
                        $display("FAIL rd_beat actual=0x%0h required=0x%0h", bm.out_data, r);
                    end
                end
            end
            if (prev_stall && bm.out_valid) chk("out_data_hold", {32'h0, bm.out_data}, {32'h0, prev_data});
            prev_stall <= bm.out_valid && !bm.out_ready;
            prev_data  <= bm.out_data;
            if (bm.done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic issue_cmd(input logic w, input logic [3:0] a, input logic [3:0] l,
                             output int c0, output bit ok);
        ok = 1'b0;
        c0 = 0;
        @(posedge clk); #1;
        bm.cmd_valid = 1'b1;
        bm.cmd_write = w;
        bm.cmd_addr  = a;
        bm.cmd_len   = l;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bm.cmd_ready) begin
                ok = 1'b1;
                c0 = cyc;
                break;
            end
        end
        chk("cmd_accept", {63'h0, ok}, 64'h1);
        if (!ok) bm.cmd_valid = 1'b0;
    endtask

    task automatic err_path(input int d0);
        @(posedge clk); #1;
        bm.cmd_valid = 1'b0;
        @(negedge clk);
        chk("err_pulse", {63'h0, bm.err}, 64'h1);
        @(negedge clk);
        chk("err_one_cycle", {63'h0, bm.err}, 64'h0);
        repeat (4) @(negedge clk);
        chk("err_no_done", 64'(done_cnt), 64'(d0));
    endtask

    // mode: 0 = in_valid held, 1 = random, 2 = 1,0,1,0,1,1 then held.
    task automatic do_write(input logic [3:0] a, input logic [3:0] l, input int mode,
                            input bit rnd, input logic [31:0] base);
        int          n;
        logic [31:0] beats [16];
        int          c0;
        bit          ok;
        int          i;
        bit          seen;
        int          d0;
        int          pat [6];
        logic        v;
        pat  = '{1, 0, 1, 0, 1, 1};
        n    = int'(l) + 1;
        i    = 0;
        seen = 1'b0;
        for (int k = 0; k < n; k++) beats[k] = rnd ? $urandom : base + 32'(k);
        if (!bound_err(a, l)) begin
            for (int k = 0; k < n; k++) begin
                logic [3:0] ad;
                ad = a + 4'(k);
                ref_mem[ad] = beats[k];
                exp_wr_q.push_back({ad, beats[k]});
            end
        end
        d0 = done_cnt;
        issue_cmd(1'b1, a, l, c0, ok);
        if (!ok) return;
        if (bound_err(a, l)) begin
            err_path(d0);
            return;
        end
        for (int t = 0; t < 200 && !seen; t++) begin
            @(posedge clk); #1;
            bm.cmd_valid = 1'b0;
            if (mode == 0)      v = 1'b1;
            else if (mode == 2) v = (t < 6) ? pat[t][0] : 1'b1;
            else                v = 1'($urandom_range(0, 1));
            bm.in_valid = (i < n) ? v : 1'b0;
            bm.in_data  = beats[i % 16];
            @(negedge clk);
            if (t == 0) chk("err_idle_wr", {63'h0, bm.err}, 64'h0);
            if (bm.in_valid && bm.in_ready) i++;
            if (bm.done) begin
                seen = 1'b1;
                if (mode == 0) chk("wr_latency", 64'(cyc - c0), 64'(n + 1));
            end
        end
        bm.in_valid = 1'b0;
        chk("wr_done", {63'h0, seen}, 64'h1);
        @(negedge clk);
        chk("wr_done_one_cycle", {63'h0, bm.done}, 64'h0);
    endtask

    // mode: 0 = out_ready held high, 1 = random, 2 = low for 3 cycles then high.
    task automatic do_read(input logic [3:0] a, input logic [3:0] l, input int mode);
        int  n;
        int  c0;
        bit  ok;
        bit  seen;
        bit  cr_seen;
        int  d0;
        int  iss0;
        int  last_hs;
        n       = int'(l) + 1;
        seen    = 1'b0;
        cr_seen = 1'b0;
        last_hs = 0;
        if (!bound_err(a, l)) begin
            for (int k = 0; k < n; k++) begin
                logic [3:0] ad;
                ad = a + 4'(k);
                exp_rd_q.push_back(ref_mem[ad]);
            end
        end
        d0   = done_cnt;
        iss0 = rd_issue_cnt;
        issue_cmd(1'b0, a, l, c0, ok);
        if (!ok) return;
        if (bound_err(a, l)) begin
            err_path(d0);
            chk("err_no_rd_issue", 64'(rd_issue_cnt), 64'(iss0));
            return;
        end
        for (int t = 0; t < 300 && !seen; t++) begin
            @(posedge clk); #1;
            bm.cmd_valid = 1'b0;
            if (mode == 0)      bm.out_ready = 1'b1;
            else if (mode == 2) bm.out_ready = (t >= 3);
            else                bm.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (t == 0) chk("err_idle_rd", {63'h0, bm.err}, 64'h0);
            if (bm.out_valid && bm.out_ready) last_hs = cyc;
            if (!bm.done && bm.cmd_ready) cr_seen = 1'b1;
            if (bm.done) begin
                seen = 1'b1;
                chk("rd_done_after_hs", 64'(cyc - last_hs), 64'h1);
                if (mode == 0) chk("rd_latency", 64'(cyc - c0), 64'(n + 2));
            end
        end
        bm.out_ready = 1'b0;
        chk("rd_done", {63'h0, seen}, 64'h1);
        @(negedge clk);
        chk("rd_done_one_cycle", {63'h0, bm.done}, 64'h0);
        chk("rd_issue_count", 64'(rd_issue_cnt - iss0), 64'(n));
        chk("cmd_ready_low_in_burst", {63'h0, cr_seen}, 64'h0);
    endtask

    // Reset two beats into an 8-beat write; only those two beats may land in the buffer.
    task automatic reset_mid_burst();
        logic [31:0] beats [8];
        int          c0;
        bit          ok;
        for (int k = 0; k < 8; k++) begin
            beats[k] = $urandom;
            exp_wr_q.push_back({4'(8 + k), beats[k]});
        end
        ref_mem[8] = beats[0];
        ref_mem[9] = beats[1];
        issue_cmd(1'b1, 4'd8, 4'd7, c0, ok);
        if (!ok) return;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bm.cmd_valid = 1'b0;
            bm.in_valid  = 1'b1;
            bm.in_data   = beats[k];
            @(negedge clk);
        end
        @(posedge clk); #1;
        reset       = 1'b1;
        bm.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_port_outputs", {60'h0, bm.buf_en, bm.buf_write, bm.in_ready, bm.cmd_ready}, 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_regs", {bm.out_data, 29'h0, bm.out_valid, bm.done, bm.err}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready_after", {63'h0, bm.cmd_ready}, 64'h1);
        chk("rst_beats_consumed", 64'(exp_wr_q.size()), 64'd6);
        exp_wr_q.delete();
    endtask

    initial begin
        bm.cmd_valid = 1'b0;
        bm.cmd_write = 1'b0;
        bm.cmd_addr  = 4'h0;
        bm.cmd_len   = 4'h0;
        bm.in_valid  = 1'b0;
        bm.in_data   = 32'h0;
        bm.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) ref_mem[k] = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_state", {58'h0, bm.cmd_ready, bm.out_valid, bm.done, bm.err, bm.buf_en, bm.in_ready}, 64'h0);
        @(posedge clk); #1;
        reset   = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", {63'h0, bm.cmd_ready}, 64'h1);

        do_write(4'd2, 4'd3, 0, 1'b0, 32'hA0);
        do_read(4'd2, 4'd3, 0);
        do_write(4'd14, 4'd3, 0, 1'b0, 32'h1);
        do_read(4'd14, 4'd3, 0);
        do_read(4'd0, 4'd1, 2);
        do_write(4'd5, 4'd3, 2, 1'b1, 32'h0);
        do_read(4'd0, 4'd15, 0);
        reset_mid_burst();
        do_read(4'd8, 4'd3, 0);

        for (int r = 0; r < 30; r++) begin
            logic [3:0] a;
            logic [3:0] l;
            a = 4'($urandom_range(0, 15));
            l = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write(a, l, $urandom_range(0, 2), 1'b1, 32'h0);
            else                           do_read(a, l, $urandom_range(0, 2));
        end

        repeat (2) @(negedge clk);
        for (int k = 0; k < 16; k++) chk($sformatf("mem_%0d", k), {32'h0, mem[k]}, {32'h0, ref_mem[k]});
        chk("wr_queue_empty", 64'(exp_wr_q.size()), 64'h0);
        chk("rd_queue_empty", 64'(exp_rd_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d_cycles required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/buffer_master.md
# buffer_master

Initiator for the 16×32 register buffer port (`en`/`write`/`Addr`/`wData`/`rData`). It accepts burst commands (start address, beat count, direction) and runs them against the buffer. Write bursts are fed from a valid/ready input stream; read bursts are delivered on a valid/ready output stream. It sits between the datapath streams and the buffer, and owns all buffer port activity.

## Interface
Parameters:
- `DATA_W`, 32: buffer word width.
- `ADDR_W`, 4: buffer address width (16 entries).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both valid and ready are high.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in `ADDR_W`: start address.
- `cmd_len` in `ADDR_W`: beats minus 1 (0..15 gives 1..16 beats).
- `in_valid`, `in_ready` in/out 1: write-data stream handshake.
- `in_data` in `DATA_W`: write data.
- `out_valid`, `out_ready` out/in 1: read-data stream handshake.
- `out_data` out `DATA_W`: read data (registered).
- `buf_en` out 1: drives buffer `en`.
- `buf_write` out 1: drives buffer `write`.
- `buf_addr` out `ADDR_W`: drives buffer `Addr`.
- `buf_wdata` out `DATA_W`: drives buffer `wData`.
- `buf_rdata` in `DATA_W`: from buffer `rData` (combinational in the buffer).
- `done` out 1: one-cycle pulse when a burst completes.
- `err` out 1: one-cycle pulse when a command is rejected (see Configuration).

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- Registers: `addr` (ADDR_W), `remain` (ADDR_W), `out_data`/`out_valid`.
- IDLE:
  - `cmd_ready` = 1 when not in reset and `out_valid` = 0.
  - On accept: `addr` ← `cmd_addr`, `remain` ← `cmd_len`, then go to WRITE or READ.
- WRITE:
  - `in_ready` = 1; `buf_en` = `in_valid`; `buf_write` = 1; `buf_addr` = `addr`; `buf_wdata` = `in_data`.
  - All of these are combinational, so the buffer captures the word on the handshake edge.
  - Each handshake: `addr` ← `addr` + 1, wrapping mod 16 (15 → 0), and `remain` decrements.
  - Handshake with `remain` = 0 → DONE.
- READ:
  - Issue is allowed when `out_valid` = 0 or `out_ready` = 1.
  - On issue: `buf_en` = 1, `buf_write` = 0, `buf_addr` = `addr`; `out_data` ← `buf_rdata` and `out_valid` ← 1 at the edge.
  - `addr` and `remain` update as in WRITE.
  - Issue with `remain` = 0 → DRAIN.
  - If `out_valid` = 1 and `out_ready` = 0, no issue happens and `out_data` holds.
- DRAIN: wait for the final `out_valid` & `out_ready` handshake (possibly in the same cycle it is entered) → DONE.
- DONE: `done` = 1 for one cycle → IDLE.
- In every state outside WRITE and READ-issue cycles: `buf_en` = 0, `buf_write` = 0, `buf_addr` = `addr`, `buf_wdata` = 0, `in_ready` = 0.
- `out_valid` clears on handshake when no new issue occurs in the same cycle.
- Reset (any state, mid-burst included):
  - State → IDLE; `addr`, `remain`, `out_data` ← 0; `out_valid`, `done`, `err` ← 0.
  - `buf_en`, `buf_write`, `in_ready`, `cmd_ready` are 0 while `reset` is high.
  - The interrupted burst is abandoned; buffer words already written stay written.

## Timing
- Command accept to first buffer access: 1 cycle (IDLE → WRITE/READ on the accept edge).
- Write throughput: 1 beat/cycle while `in_valid` is held. An N-beat write takes N cycles, then `done` in the next cycle.
- Read latency: the issue cycle presents the address; `out_valid` rises the next cycle. Throughput is 1 beat/cycle with `out_ready` held high.
- Read `done` is asserted the cycle after the final output handshake.
- Back-to-back: a new command is accepted the cycle after DONE.

## Configuration
- `BUFFER_MASTER_BOUND_CHECK_EN` defined:
  - A command with `cmd_addr` + `cmd_len` > 15 is accepted (`cmd_ready` handshake completes) but not executed.
  - `err` pulses for 1 cycle, the FSM stays in IDLE, and no buffer access or `done` occurs.
- Not defined: bursts wrap mod 16 and `err` is tied to 0.

## Test plan
- Write then read: write addr 2, len 3, data 0xA0..0xA3 with `in_valid` held → buffer entries 2..5 = 0xA0..0xA3, `done` 5 cycles after accept. Then read addr 2, len 3 with `out_ready`=1 → `out_data` 0xA0..0xA3 on consecutive cycles.
- Wrap: write addr 14, len 3, data 1..4 → entries 14, 15, 0, 1 = 1, 2, 3, 4. With the macro defined, the same command instead gives an `err` pulse, no `buf_en`, and no `done`.
- Read backpressure: read addr 0, len 1, with `out_ready` low for 3 cycles → `out_data` = entry 0 held stable, only one `buf_en` read issue, and `done` 1 cycle after the `out_ready` handshake.
- Write stall: `in_valid` toggles 1,0,1,0,1,1 on a len-3 write → exactly 4 buffer writes at consecutive addresses, and `buf_en` = 0 on the idle cycles.
- Reset mid-burst: assert `reset` after 2 beats of a len-7 write → all outputs 0 during reset, `cmd_ready` = 1 the cycle after release, and entries beyond beat 2 unchanged.
- 16-beat read, addr 0, len 15 → 16 outputs, `done` once, `cmd_ready` low throughout.
